// File: rtl/crc32_rx_checker_pkg.sv
`default_nettype none
// ============================================================================
// Package  : crc32_pkg
// Brief    : CRC-32 constants, receive-checker state encoding and the
//            byte-wise CRC update shared by receive and transmit paths.
// Revision : 1.0 - initial release
// ============================================================================
package crc32_pkg;

    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;  // bit-reversed CRC_POLY
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        CHECK  = 2'd3
    } crc32_state_e;

    // Reflected: LSB-first into a reflected register; otherwise MSB-first.
    function automatic logic [31:0] crc32_byte_next(
        input logic [31:0] crc,
        input logic [7:0]  data,
        input logic        reflected
    );
        logic [31:0] c;
        c = crc;
        if (reflected) begin
            c = c ^ {24'd0, data};
            for (int i = 0; i < 8; i++) begin
                c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
            end
        end else begin
            c = c ^ {data, 24'd0};
            for (int i = 0; i < 8; i++) begin
                c = c[31] ? ((c << 1) ^ CRC_POLY) : (c << 1);
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_rx_checker_if.sv
`default_nettype none
// ============================================================================
// Interface : crc32_rx_checker_if
// Brief     : Framed byte stream in, payload stream and check result out.
// Revision  : 1.0 - initial release
// ============================================================================
interface crc32_rx_checker_if;

    logic        clc;
    logic        crc_mode;
    logic [7:0]  d_in;
    logic        d_vld;
    logic        d_sof;
    logic        d_eof;

    logic [7:0]  q_out;
    logic        q_vld;
    logic        q_sof;
    logic        q_eof;
    logic        chk_done;
    logic        chk_ok;
    logic        chk_runt;
    logic [31:0] chk_crc;

    modport master (
        output clc, crc_mode, d_in, d_vld, d_sof, d_eof,
        input  q_out, q_vld, q_sof, q_eof, chk_done, chk_ok, chk_runt, chk_crc
    );

    modport slave (
        input  clc, crc_mode, d_in, d_vld, d_sof, d_eof,
        output q_out, q_vld, q_sof, q_eof, chk_done, chk_ok, chk_runt, chk_crc
    );

endinterface
`default_nettype wire

// File: rtl/crc32_rx_checker_engine.sv
`default_nettype none
// ============================================================================
// Module   : crc32_engine
// Brief    : CRC-32 register with init/enable; crc_next is the register value
//            with this cycle's byte applied when en is high.
// Revision : 1.0 - initial release
// ============================================================================
module crc32_engine
    import crc32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic        mode,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] r_crc;

    // mode 0 is the reflected IEEE variant
    assign crc_next = en ? crc32_byte_next(r_crc, data, ~mode) : r_crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= CRC_INIT;
        end else if (init) begin
            r_crc <= CRC_INIT;
        end else if (en) begin
            r_crc <= crc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/crc32_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : crc32_rx_checker
// Brief    : Strips the 4-byte FCS through a delay line, forwards the payload
//            and reports the CRC-32 check result at end of frame.
// Revision : 1.0 - initial release
// ============================================================================
module crc32_rx_checker
    import crc32_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    crc32_rx_checker_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_FILL   = 2'(FILL);
    localparam logic [1:0] ST_STREAM = 2'(STREAM);
    localparam logic [1:0] ST_CHECK  = 2'(CHECK);

    localparam logic [2:0] C_CNT_FULL = 3'd4;
    localparam logic [2:0] C_CNT_SAT  = 3'd5;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  r_cnt;
    logic        r_mode;
    logic [7:0]  r_dly [4];

    logic        w_acc;
    logic        w_sof;
    logic        w_sof_eof;
    logic        w_in_frame;
    logic        w_byte;
    logic        w_exit;
    logic        w_eof;
    logic        w_runt;
    logic [31:0] w_crc_next;
    logic [31:0] w_crc_fin;
    logic [31:0] w_fcs;

    logic [7:0]  r_q_out;
    logic        r_q_vld;
    logic        r_q_sof;
    logic        r_q_eof;
    logic        r_chk_done;
    logic        r_chk_ok;
    logic        r_chk_runt;
    logic [31:0] r_chk_crc;

    // clc blocks acceptance so it wins over d_vld in the same cycle
    assign w_acc      = bus.d_vld & ~bus.clc;
    assign w_sof      = w_acc & bus.d_sof;
    assign w_sof_eof  = w_sof & bus.d_eof;
    assign w_in_frame = (r_state == ST_FILL) || (r_state == ST_STREAM);
    assign w_byte     = w_acc & ~bus.d_sof & w_in_frame;
    assign w_exit     = w_byte & (r_cnt >= C_CNT_FULL);
    assign w_eof      = w_byte & bus.d_eof;
    assign w_runt     = r_cnt < C_CNT_FULL;

    crc32_engine u_engine (
        .clk      (clk),
        .rst      (rst),
        .init     (w_sof),
        .en       (w_exit),
        .mode     (r_mode),
        .data     (r_dly[3]),
        .crc_next (w_crc_next)
    );

    assign w_crc_fin = w_crc_next ^ CRC_XOROUT;

    // Held bytes in arrival order are r_dly[2], r_dly[1], r_dly[0], d_in.
    assign w_fcs = r_mode ? {r_dly[2], r_dly[1], r_dly[0], bus.d_in}
                          : {bus.d_in, r_dly[0], r_dly[1], r_dly[2]};

    always_comb begin
        w_state_nxt = r_state;
        if (bus.clc) begin
            w_state_nxt = ST_IDLE;
        end else if (w_sof) begin
            w_state_nxt = bus.d_eof ? ST_CHECK : ST_FILL;
        end else if (r_state == ST_CHECK) begin
            w_state_nxt = ST_IDLE;
        end else if (w_eof) begin
            w_state_nxt = ST_CHECK;
        end else if (w_exit) begin
            w_state_nxt = ST_STREAM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clc) begin
            r_cnt  <= '0;
            r_mode <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_dly[i] <= '0;
            end
        end else if (w_sof) begin
            r_cnt    <= 3'd1;
            r_mode   <= bus.crc_mode;
            r_dly[0] <= bus.d_in;
            r_dly[1] <= '0;
            r_dly[2] <= '0;
            r_dly[3] <= '0;
        end else if (w_byte) begin
            if (r_cnt != C_CNT_SAT) begin
                r_cnt <= r_cnt + 3'd1;
            end
            r_dly[0] <= bus.d_in;
            r_dly[1] <= r_dly[0];
            r_dly[2] <= r_dly[1];
            r_dly[3] <= r_dly[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_out    <= '0;
            r_q_vld    <= 1'b0;
            r_q_sof    <= 1'b0;
            r_q_eof    <= 1'b0;
            r_chk_done <= 1'b0;
            r_chk_ok   <= 1'b0;
            r_chk_runt <= 1'b0;
            r_chk_crc  <= '0;
        end else begin
            r_q_vld    <= w_exit;
            r_q_sof    <= w_exit && (r_cnt == C_CNT_FULL);
            r_q_eof    <= w_exit && bus.d_eof;
            r_chk_done <= w_eof || w_sof_eof;
            if (w_exit) begin
                r_q_out <= r_dly[3];
            end
            if (w_eof) begin
                r_chk_ok   <= ~w_runt && (w_fcs == w_crc_fin);
                r_chk_runt <= w_runt;
                r_chk_crc  <= w_crc_fin;
            end else if (w_sof_eof) begin
                r_chk_ok   <= 1'b0;
                r_chk_runt <= 1'b1;
                r_chk_crc  <= CRC_INIT ^ CRC_XOROUT;
            end
        end
    end

    assign bus.q_out    = r_q_out;
    assign bus.q_vld    = r_q_vld;
    assign bus.q_sof    = r_q_sof;
    assign bus.q_eof    = r_q_eof;
    assign bus.chk_done = r_chk_done;
    assign bus.chk_ok   = r_chk_ok;
    assign bus.chk_runt = r_chk_runt;
    assign bus.chk_crc  = r_chk_crc;

endmodule
`default_nettype wire

// File: tb/tb_crc32_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc32_rx_checker
// Brief    : Directed vector table plus hand-written frame sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc32_rx_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;

    crc32_rx_checker_if bus ();

    crc32_rx_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic        s;
        logic        e;
        logic [7:0]  d;
        logic        ev;
        logic [7:0]  eq;
        logic        es;
        logic        ee;
        logic        edn;
        logic        eok;
        logic        ert;
        logic [31:0] ec;
    } vec_t;

    vec_t       tbl [$];
    logic [7:0] frm [13];
    logic [7:0] rx_q [$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         sof_cnt, eof_cnt, done_cnt;
    logic       last_ok, last_runt;
    logic [31:0] last_crc;

    function automatic vec_t mk(input logic m, s, e, input logic [7:0] d,
                                input logic ev, input logic [7:0] eq,
                                input logic es, ee, edn, eok, ert,
                                input logic [31:0] ec);
        vec_t v;
        v.m = m; v.s = s; v.e = e; v.d = d; v.ev = ev; v.eq = eq;
        v.es = es; v.ee = ee; v.edn = edn; v.eok = eok; v.ert = ert; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clear_stats();
        rx_q.delete();
        sof_cnt  = 0;
        eof_cnt  = 0;
        done_cnt = 0;
        last_ok  = 1'b0;
        last_runt = 1'b0;
        last_crc = '0;
    endtask

    task automatic collect();
        if (bus.q_vld) rx_q.push_back(bus.q_out);
        if (bus.q_sof) sof_cnt++;
        if (bus.q_eof) eof_cnt++;
        if (bus.chk_done) begin
            done_cnt++;
            last_ok   = bus.chk_ok;
            last_runt = bus.chk_runt;
            last_crc  = bus.chk_crc;
        end
    endtask

    task automatic step(input logic v, s, e, input logic [7:0] d, input logic m);
        bus.d_vld    = v;
        bus.d_sof    = s;
        bus.d_eof    = e;
        bus.d_in     = d;
        bus.crc_mode = m;
        @(posedge clk);
        #1;
        collect();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // sof byte is always sent in mode 0; later bytes carry mid_mode
    task automatic send_range(input int lo, input int hi, input logic mid_mode);
        for (int i = lo; i <= hi; i++) begin
            step(1'b1, i == 0, i == 12, frm[i], (i == 0) ? 1'b0 : mid_mode);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.clc = 1'b0; bus.crc_mode = 1'b0; bus.d_in = '0;
        bus.d_vld = 1'b0; bus.d_sof = 1'b0; bus.d_eof = 1'b0;
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};

        // mode 0 pass, mode 1 pass, 4-byte runt, 1-byte runt: all back to back
        tbl.push_back(mk(0,1,0,8'h31, 0,8'h00,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,8'h32, 0,8'h00,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,8'h33, 0,8'h00,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,8'h34, 0,8'h00,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,8'h35, 1,8'h31,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,8'h36, 1,8'h32,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,8'h37, 1,8'h33,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,8'h38, 1,8'h34,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,8'h39, 1,8'h35,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,8'h26, 1,8'h36,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,8'h39, 1,8'h37,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,8'hF4, 1,8'h38,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,8'hCB, 1,8'h39,0,1,1,1,0,32'hCBF43926));
        tbl.push_back(mk(1,1,0,8'h31, 0,8'h00,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h32, 0,8'h00,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h33, 0,8'h00,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h34, 0,8'h00,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h35, 1,8'h31,1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h36, 1,8'h32,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h37, 1,8'h33,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h38, 1,8'h34,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h39, 1,8'h35,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,8'hFC, 1,8'h36,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h89, 1,8'h37,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,8'h19, 1,8'h38,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1,8'h18, 1,8'h39,0,1,1,1,0,32'hFC891918));
        tbl.push_back(mk(0,1,0,8'h61, 0,8'h00,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,8'h61, 0,8'h00,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,8'h61, 0,8'h00,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,8'h61, 0,8'h00,0,0,1,0,1,0));
        tbl.push_back(mk(0,1,1,8'hAA, 0,8'h00,0,0,1,0,1,0));

        repeat (3) @(posedge clk);
        #1;
        chk("reset q_vld",    32'(bus.q_vld),    32'd0);
        chk("reset q_out",    32'(bus.q_out),    32'd0);
        chk("reset chk_done", 32'(bus.chk_done), 32'd0);
        chk("reset chk_ok",   32'(bus.chk_ok),   32'd0);
        chk("reset chk_runt", 32'(bus.chk_runt), 32'd0);
        chk("reset chk_crc",  bus.chk_crc,       32'd0);
        rst = 1'b0;
        clear_stats();

        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b1, tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].m);
            chk($sformatf("vec%0d q_vld", i),    32'(bus.q_vld),    32'(tbl[i].ev));
            chk($sformatf("vec%0d q_sof", i),    32'(bus.q_sof),    32'(tbl[i].es));
            chk($sformatf("vec%0d q_eof", i),    32'(bus.q_eof),    32'(tbl[i].ee));
            chk($sformatf("vec%0d chk_done", i), 32'(bus.chk_done), 32'(tbl[i].edn));
            if (tbl[i].ev) chk($sformatf("vec%0d q_out", i), 32'(bus.q_out), 32'(tbl[i].eq));
            if (tbl[i].edn) begin
                chk($sformatf("vec%0d chk_ok", i),   32'(bus.chk_ok),   32'(tbl[i].eok));
                chk($sformatf("vec%0d chk_runt", i), 32'(bus.chk_runt), 32'(tbl[i].ert));
                if (!tbl[i].ert) chk($sformatf("vec%0d chk_crc", i), bus.chk_crc, tbl[i].ec);
            end
        end
        idle(2);

        // corrupted payload byte still forwarded, check fails
        clear_stats();
        frm[2] = 8'h73;
        send_range(0, 12, 1'b0);
        idle(1);
        frm[2] = 8'h33;
        chk("corrupt payload count", 32'(rx_q.size()), 32'd9);
        if (rx_q.size() == 9) chk("corrupt byte fwd", 32'(rx_q[2]), 32'h73);
        chk("corrupt done count", 32'(done_cnt), 32'd1);
        chk("corrupt chk_ok", 32'(last_ok), 32'd0);
        chk("corrupt crc differs", 32'(last_crc != 32'hCBF43926), 32'd1);

        // 3-cycle gap after byte 35, crc_mode toggled mid-frame
        clear_stats();
        send_range(0, 4, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        send_range(5, 12, 1'b1);
        idle(1);
        chk("gap payload count", 32'(rx_q.size()), 32'd9);
        if (rx_q.size() == 9) begin
            chk("gap first byte", 32'(rx_q[0]), 32'h31);
            chk("gap last byte",  32'(rx_q[8]), 32'h39);
        end
        chk("gap sof count",  32'(sof_cnt),  32'd1);
        chk("gap eof count",  32'(eof_cnt),  32'd1);
        chk("gap done count", 32'(done_cnt), 32'd1);
        chk("gap chk_ok",     32'(last_ok),  32'd1);
        chk("gap chk_crc",    last_crc,      32'hCBF43926);

        // clc after byte 36, asserted together with a valid byte
        clear_stats();
        send_range(0, 5, 1'b0);
        bus.clc = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h37, 1'b0);
        bus.clc = 1'b0;
        send_range(7, 12, 1'b0);
        idle(2);
        chk("clc no done", 32'(done_cnt), 32'd0);
        chk("clc no eof",  32'(eof_cnt),  32'd0);
        clear_stats();
        send_range(0, 12, 1'b0);
        idle(1);
        chk("after clc done", 32'(done_cnt), 32'd1);
        chk("after clc ok",   32'(last_ok),  32'd1);

        // sof inside frame 1 restarts; only frame 2 reports
        clear_stats();
        send_range(0, 6, 1'b0);
        send_range(0, 12, 1'b0);
        idle(1);
        chk("restart done count", 32'(done_cnt), 32'd1);
        chk("restart eof count",  32'(eof_cnt),  32'd1);
        chk("restart sof count",  32'(sof_cnt),  32'd2);
        chk("restart chk_ok",     32'(last_ok),  32'd1);
        chk("restart chk_crc",    last_crc,      32'hCBF43926);

        // reset mid-frame clears held results and aborts the frame
        clear_stats();
        send_range(0, 7, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h39, 1'b0);
        rst = 1'b0;
        chk("rst q_vld",   32'(bus.q_vld),  32'd0);
        chk("rst chk_ok",  32'(bus.chk_ok), 32'd0);
        chk("rst chk_crc", bus.chk_crc,     32'd0);
        send_range(9, 12, 1'b0);
        idle(2);
        chk("rst no done", 32'(done_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
